// File: rtl/anthem_sequencer.sv
// Character sequencer: walks a ROM of MSG_LEN characters, presenting each on char_out for DWELL cycles.
// Optional build macro ANTHEM_LOOP_EN: when defined the message repeats until stop or rst.
module anthem_sequencer #(
  parameter int MSG_LEN = 21,
  parameter int DWELL   = 1000,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        char_out,
  output logic              char_valid,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(DWELL - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_SHOW,
    S_END
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        char_q, char_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              first_q, first_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    char_d  = char_q;
    cnt_d   = cnt_q;
    first_d = 1'b0;

    // stop outranks every transition, including start in IDLE
    if (stop) begin
      state_d = S_IDLE;
      addr_d  = '0;
      char_d  = 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_FETCH;
            addr_d  = '0;
          end
        end
        S_FETCH: state_d = S_LATCH;
        S_LATCH: begin
          char_d  = rom_data;
          cnt_d   = CNT_LOAD;
          first_d = 1'b1;
          state_d = S_SHOW;
        end
        S_SHOW: begin
          if (!pause) begin
            if (cnt_q == '0) begin
              if (addr_q == LAST_ADDR) begin
                state_d = S_END;
              end else begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = S_FETCH;
              end
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        S_END: begin
`ifdef ANTHEM_LOOP_EN
          state_d = S_FETCH;
          addr_d  = '0;
`else
          state_d = S_IDLE;
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      char_q  <= 8'h00;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      char_q  <= char_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  // first_q is set only on the LATCH->SHOW edge, so pause cannot stretch char_valid
  assign rom_addr   = addr_q;
  assign char_out   = char_q;
  assign char_valid = first_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_END);

endmodule

// File: tb/tb_anthem_sequencer.sv
// Scoreboard bench for anthem_sequencer: random start/stop/pause runs checked against an event-level model.
module tb_anthem_sequencer;

  localparam int MSG_LEN = 3;
  localparam int DWELL   = 4;
  localparam int ADDR_W  = 8;
  localparam int NRUNS   = 30;
`ifdef ANTHEM_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  typedef struct {
    bit         is_done;
    int         cyc;
    logic [7:0] ch;
  } ev_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              stop;
  logic              pause;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [7:0]        char_out;
  logic              char_valid;
  logic              busy;
  logic              done;

  logic [7:0] rom_img [MSG_LEN] = '{8'h53, 8'h6F, 8'h79};
  ev_t        exp_q [$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  anthem_sequencer #(
    .MSG_LEN(MSG_LEN),
    .DWELL  (DWELL),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .char_out  (char_out),
    .char_valid(char_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (int'(rom_addr) < MSG_LEN) rom_data <= rom_img[int'(rom_addr)];
    else rom_data <= 8'h00;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // monitor: pops one expected event whenever the DUT flags char_valid or done
  initial begin
    ev_t ev;
    forever begin
      @(negedge clk);
      if (!rst && (char_valid || done)) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event cyc=%0d char_valid=%0b done=%0b char_out=%02h expected=none",
                   cyc, char_valid, done, char_out);
        end else begin
          ev = exp_q.pop_front();
          if (done != ev.is_done || char_valid == ev.is_done || cyc != ev.cyc ||
              (!ev.is_done && char_out !== ev.ch)) begin
            failures++;
            $display("FAIL event cyc=%0d actual(valid=%0b done=%0b char=%02h) expected(cyc=%0d done=%0b char=%02h)",
                     cyc, char_valid, done, char_out, ev.cyc, ev.is_done, ev.ch);
          end else begin
            $display("event cyc=%0d %s char=%02h", cyc, done ? "done" : "char", char_out);
          end
        end
      end
    end
  end

  task automatic do_run(input int r);
    bit   pv [0:399];
    ev_t  evs [$];
    ev_t  e;
    int   x, s, t, sh, c, cnt, done_rel, end_rel, limit, rel;
    bit   fin;

    for (int i = 0; i < 400; i++) begin
      if (r == 1) pv[i] = (i >= 4 && i <= 8);
      else if (r >= 3) pv[i] = ($urandom_range(0, 3) == 0);
      else pv[i] = 1'b0;
    end
    x = -1;
    if (r == 2) x = 10;
    else if (r >= 3 && $urandom_range(0, 2) == 0) x = $urandom_range(1, 40);
    if (LOOP && x < 0) x = $urandom_range(20, 60);

    // model: each character shows for DWELL unpaused cycles, with 2 cycles of fetch overhead
    limit = LOOP ? x : 100000;
    t = 1;
    done_rel = -1;
    fin = 1'b0;
    while (!fin) begin
      for (int k = 0; k < MSG_LEN && !fin; k++) begin
        sh = t + 2;
        if (sh > limit) fin = 1'b1;
        else begin
          evs.push_back('{1'b0, sh, rom_img[k]});
          c = sh;
          cnt = 0;
          forever begin
            if (c >= 399 || !pv[c]) cnt++;
            if (cnt == DWELL) break;
            c++;
          end
          t = c + 1;
        end
      end
      if (!fin) begin
        if (t > limit) fin = 1'b1;
        else begin
          evs.push_back('{1'b1, t, 8'h00});
          done_rel = t;
          if (LOOP) t = t + 1;
          else fin = 1'b1;
        end
      end
    end
    if (!LOOP && x > done_rel) x = -1;
    end_rel = (x >= 0) ? x : done_rel;

    s = cyc;
    foreach (evs[i]) begin
      e = evs[i];
      if (x < 0 || e.cyc <= x) begin
        e.cyc = e.cyc + s;
        exp_q.push_back(e);
      end
    end

    start = 1'b1;
    stop  = 1'b0;
    pause = pv[0];
    rel = 0;
    while (rel <= end_rel) begin
      @(posedge clk);
      #1;
      rel = cyc - s;
      if (rel <= end_rel) chk("busy_run", int'(busy), 1);
      pause = pv[rel];
      stop  = (rel == x);
      start = (rel <= end_rel) && ($urandom_range(0, 4) == 0);
    end
    chk("busy_after", int'(busy), 0);
    chk("char_out_after", int'(char_out), (x >= 0) ? 0 : int'(rom_img[MSG_LEN-1]));
    chk("rom_addr_after", int'(rom_addr), (x >= 0) ? 0 : MSG_LEN - 1);
    chk("events_drained", exp_q.size(), 0);
    exp_q.delete();
    start = 1'b0;
    stop  = 1'b0;
    pause = 1'b0;
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    stop  = 1'b0;
    pause = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(char_valid), 0);
    chk("rst_char", int'(char_out), 0);
    chk("rst_addr", int'(rom_addr), 0);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("start_in_rst_ignored", int'(busy), 0);
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk);
    #1;
    chk("start_stop_idle", int'(busy), 0);
    start = 1'b0;
    stop  = 1'b0;
    @(posedge clk);
    #1;
    for (int r = 0; r < NRUNS; r++) do_run(r);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
